insn_queue: RTL and testbench
=============================

// Module: insn_queue
// PURPOSE
//   Circular instruction queue directly downstream of the fetch aligner. Accepts up to four
//   aligned decoded instructions per cycle (valid mask MSB = oldest) and presents the two
//   oldest entries to the issue stage, which dequeues 0-2 per cycle. Decouples fetch bursts
//   from issue rate; cleared on branch mispredict/redirect via i_Flush.
// PARAMETERS
//   INSN_WIDTH  99  width of one decoded instruction word
//   DEPTH       16  queue entries; power of two, >= 8
//   PTR_WIDTH   4   log2(DEPTH)
// PORTS
//   i_Clk          in   1             clock, all state on rising edge
//   i_Reset_n      in   1             asynchronous active-low reset
//   i_Flush        in   1             synchronous clear of all entries
//   i_valid        in   4             push mask; bit3=i_isn1 ... bit0=i_isn4
//   i_isn1..i_isn4 in   INSN_WIDTH    aligned instructions, i_isn1 oldest
//   o_ready        out  1             queue can accept a full 4-wide push this cycle
//   i_pop_count    in   2             entries issue consumes this cycle (0,1,2; 3 treated as 2)
//   o_head_valid   out  2             bit1 = o_head_isn0 valid, bit0 = o_head_isn1 valid
//   o_head_isn0    out  INSN_WIDTH    oldest entry
//   o_head_isn1    out  INSN_WIDTH    second-oldest entry
//   o_count        out  PTR_WIDTH+1   occupied entries, 0..DEPTH
// BEHAVIOUR
//   - Reset (async): rd_ptr=wr_ptr=0, count=0; o_ready=1, o_head_valid=2'b00,
//     o_head_isn0/1=0, o_count=0. Storage array contents need not be reset.
//   - Push number push_n = leading ones of i_valid from bit3 (1000->1, 1100->2, 1110->3,
//     1111->4, 0xxx->0). Bits after first zero ignored (e.g. 1011 -> 1).
//   - Push accepted only when o_ready=1; o_ready = (DEPTH - count) >= 4, from registered
//     count only (no pop bypass). i_valid while o_ready=0 is dropped; upstream must stall.
//   - Accepted push writes i_isn1..i_isnN to wr_ptr, wr_ptr+1, ... mod DEPTH; wr_ptr += push_n.
//   - pop_n = min(i_pop_count clamped to 2, count). Popping beyond count never underflows.
//     rd_ptr += pop_n mod DEPTH.
//   - count_next = count + push_n - pop_n; push and pop in same cycle both take effect.
//   - Head outputs combinational from registered state: o_head_isn0 = mem[rd_ptr] when
//     count>=1 else 0; o_head_isn1 = mem[rd_ptr+1] when count>=2 else 0;
//     o_head_valid = {count>=1, count>=2}. No same-cycle bypass: push in cycle N visible at
//     head in cycle N+1 (1-cycle latency, including when queue empty).
//   - Pointers wrap modulo DEPTH; a push spanning the wrap (e.g. wr_ptr=14, 4 entries) writes
//     14,15,0,1.
//   - i_Flush: priority over push and pop in same cycle; next cycle ptrs=0, count=0,
//     o_head_valid=00, o_ready=1. Instructions presented with i_Flush are discarded.
//   - Full: count=DEPTH -> o_ready=0, head still valid; count in DEPTH-3..DEPTH -> o_ready=0.
//   - Reset asserted mid-operation clears immediately regardless of clock; all entries lost.
// TESTING
//   1. Reset, push i_valid=1111 (A,B,C,D), pop 0 -> next cycle o_count=4, heads A,B, valid 11.
//   2. Push 1100 (E,F) and pop 2 same cycle from count=4 -> count=4, heads C,D; then heads
//      E,F after next pop 2.
//   3. Fill to 13 -> o_ready=0; push 1111 dropped, count stays 13; pop 1 -> o_ready=1 next.
//   4. Wrap: advance ptrs to 14, push 1111 (W,X,Y,Z), pop 2 x2 -> heads W,X then Y,Z; count 0.
//   5. count=1, i_pop_count=3 -> pop_n=1, count=0, o_head_valid=00, outputs 0.
//   6. count=9 with push 1110 and i_Flush=1 -> count=0, valid 00; async reset mid-burst
//      clears o_count to 0 before next edge.

Source files
------------

// File: rtl/insn_queue.sv
// Circular instruction queue between the fetch aligner and issue.
// Accepts up to four aligned instructions per cycle (i_valid MSB = oldest) and
// presents the two oldest entries to issue, which retires 0-2 per cycle.
// Head outputs are combinational from registered state, so a push becomes
// visible at the head one cycle later, even when the queue was empty.
module insn_queue #(
  parameter int INSN_WIDTH = 99,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  input  logic                  i_Flush,
  input  logic [3:0]            i_valid,
  input  logic [INSN_WIDTH-1:0] i_isn1,
  input  logic [INSN_WIDTH-1:0] i_isn2,
  input  logic [INSN_WIDTH-1:0] i_isn3,
  input  logic [INSN_WIDTH-1:0] i_isn4,
  output logic                  o_ready,
  input  logic [1:0]            i_pop_count,
  output logic [1:0]            o_head_valid,
  output logic [INSN_WIDTH-1:0] o_head_isn0,
  output logic [INSN_WIDTH-1:0] o_head_isn1,
  output logic [PTR_WIDTH:0]    o_count
);

  // A full 4-wide push fits only while at least four slots are free.
  localparam logic [PTR_WIDTH:0] READY_MAX = (PTR_WIDTH+1)'(DEPTH - 4);

  logic [INSN_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;

  logic [INSN_WIDTH-1:0] isn_w [4];
  logic [2:0]            push_raw;
  logic [2:0]            push_n;
  logic [1:0]            pop_req;
  logic [1:0]            pop_n;
  logic                  ready;
  logic [PTR_WIDTH-1:0]  rd_ptr_nx;

  assign isn_w[0] = i_isn1;
  assign isn_w[1] = i_isn2;
  assign isn_w[2] = i_isn3;
  assign isn_w[3] = i_isn4;

  // Push size is the run of ones from bit3; anything after the first zero is ignored.
  always_comb begin
    push_raw = 3'd0;
    casez (i_valid)
      4'b1111: push_raw = 3'd4;
      4'b1110: push_raw = 3'd3;
      4'b110?: push_raw = 3'd2;
      4'b10??: push_raw = 3'd1;
      default: push_raw = 3'd0;
    endcase
  end

  // Accept/consume amounts: push gated by registered ready, pop clamped to 2 and to occupancy.
  always_comb begin
    ready   = (count_q <= READY_MAX);
    push_n  = (ready && !i_Flush) ? push_raw : 3'd0;
    pop_req = (i_pop_count == 2'd3) ? 2'd2 : i_pop_count;
    if (count_q < {{(PTR_WIDTH-1){1'b0}}, pop_req}) begin
      pop_n = count_q[1:0];
    end else begin
      pop_n = pop_req;
    end
  end

  // Next pointer/count values; flush wins over any push or pop this cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop_n);
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(push_n);
      count_d  = count_q + (PTR_WIDTH+1)'(push_n) - (PTR_WIDTH+1)'(pop_n);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage writes; no reset on the array, entries are qualified by count.
  always_ff @(posedge i_Clk) begin
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < push_n) begin
        mem_q[wr_ptr_q + PTR_WIDTH'(k)] <= isn_w[k];
      end
    end
  end

  // Head presentation, zeroed when the slot is not occupied.
  always_comb begin
    rd_ptr_nx    = rd_ptr_q + PTR_WIDTH'(1);
    o_head_valid = {count_q != '0, count_q >= (PTR_WIDTH+1)'(2)};
    o_head_isn0  = o_head_valid[1] ? mem_q[rd_ptr_q]  : '0;
    o_head_isn1  = o_head_valid[0] ? mem_q[rd_ptr_nx] : '0;
  end

  assign o_ready = ready;
  assign o_count = count_q;

endmodule

// File: tb/tb_insn_queue.sv
// Randomized bench for insn_queue against a queue-based reference model.
module tb_insn_queue;

  localparam int W = 99;
  localparam int D = 16;

  logic         i_Clk;
  logic         i_Reset_n;
  logic         i_Flush;
  logic [3:0]   i_valid;
  logic [W-1:0] i_isn1, i_isn2, i_isn3, i_isn4;
  logic         o_ready;
  logic [1:0]   i_pop_count;
  logic [1:0]   o_head_valid;
  logic [W-1:0] o_head_isn0, o_head_isn1;
  logic [4:0]   o_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mq [$];

  insn_queue #(.INSN_WIDTH(W), .DEPTH(D), .PTR_WIDTH(4)) dut (
    .i_Clk        (i_Clk),
    .i_Reset_n    (i_Reset_n),
    .i_Flush      (i_Flush),
    .i_valid      (i_valid),
    .i_isn1       (i_isn1),
    .i_isn2       (i_isn2),
    .i_isn3       (i_isn3),
    .i_isn4       (i_isn4),
    .o_ready      (o_ready),
    .i_pop_count  (i_pop_count),
    .o_head_valid (o_head_valid),
    .o_head_isn0  (o_head_isn0),
    .o_head_isn1  (o_head_isn1),
    .o_count      (o_count)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // Single comparison point: counts every check, reports any mismatch.
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_isn();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Compare every output against the model's current contents.
  task automatic check_all();
    int sz;
    logic [W-1:0] h0, h1;
    sz = mq.size();
    h0 = (sz >= 1) ? mq[0] : '0;
    h1 = (sz >= 2) ? mq[1] : '0;
    chk("count", o_count, sz);
    chk("ready", o_ready, (D - sz) >= 4);
    chk("head_valid", o_head_valid, {sz >= 1, sz >= 2});
    chk("head0", o_head_isn0, h0);
    chk("head1", o_head_isn1, h1);
  endtask

  // Called at a falling edge: drive inputs, advance the model, clock once, check.
  task automatic cycle(input logic [3:0] v, input logic [1:0] pc, input logic fl,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    int pn;
    int popn;
    bit rdy;
    logic [W-1:0] vals [4];
    i_valid = v; i_pop_count = pc; i_Flush = fl;
    i_isn1 = a; i_isn2 = b; i_isn3 = c; i_isn4 = d;
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    pn = 0;
    for (int bit_i = 3; bit_i >= 0; bit_i--) begin
      if (v[bit_i]) pn++;
      else break;
    end
    rdy  = (D - mq.size()) >= 4;
    popn = (pc == 2'd3) ? 2 : int'(pc);
    if (popn > mq.size()) popn = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      repeat (popn) void'(mq.pop_front());
      if (rdy) for (int k = 0; k < pn; k++) mq.push_back(vals[k]);
    end
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_valid = 4'b0; i_pop_count = 2'd0; i_Flush = 1'b0;
    check_all();
  endtask

  task automatic push4(input logic [3:0] v);
    cycle(v, 2'd0, 1'b0, rnd_isn(), rnd_isn(), rnd_isn(), rnd_isn());
  endtask

  task automatic idle(input logic [1:0] pc);
    cycle(4'b0000, pc, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic flush();
    cycle(4'b0000, 2'd0, 1'b1, '0, '0, '0, '0);
  endtask

  initial begin
    logic [3:0] v;
    i_Reset_n = 1'b0; i_Flush = 1'b0; i_valid = 4'b0; i_pop_count = 2'd0;
    i_isn1 = '0; i_isn2 = '0; i_isn3 = '0; i_isn4 = '0;
    repeat (2) @(negedge i_Clk);
    i_Reset_n = 1'b1;
    check_all();

    // 1: full push, no pop
    cycle(4'b1111, 2'd0, 1'b0, 99'hA, 99'hB, 99'hC, 99'hD);
    chk("t1_h0", o_head_isn0, 99'hA);
    chk("t1_h1", o_head_isn1, 99'hB);

    // 2: push two while popping two
    cycle(4'b1100, 2'd2, 1'b0, 99'hE, 99'hF, 99'h77, 99'h78);
    chk("t2_count", o_count, 4);
    chk("t2_h0", o_head_isn0, 99'hC);
    idle(2'd2);
    chk("t2_h0b", o_head_isn0, 99'hE);
    chk("t2_h1b", o_head_isn1, 99'hF);

    // 3: fill to 13, dropped push, pop restores ready
    flush();
    push4(4'b1111); push4(4'b1111); push4(4'b1111);
    push4(4'b1011);
    chk("t3_count", o_count, 13);
    chk("t3_ready", o_ready, 1'b0);
    push4(4'b1111);
    chk("t3_drop", o_count, 13);
    idle(2'd1);
    chk("t3_ready_back", o_ready, 1'b1);

    // 4: wrap with pointers at 14
    flush();
    push4(4'b1111); push4(4'b1111); push4(4'b1111); push4(4'b1101);
    repeat (7) idle(2'd2);
    chk("t4_empty", o_count, 0);
    cycle(4'b1111, 2'd0, 1'b0, 99'h57, 99'h58, 99'h59, 99'h5A);
    chk("t4_h0", o_head_isn0, 99'h57);
    chk("t4_h1", o_head_isn1, 99'h58);
    idle(2'd2);
    chk("t4_h0b", o_head_isn0, 99'h59);
    chk("t4_h1b", o_head_isn1, 99'h5A);
    idle(2'd2);
    chk("t4_count", o_count, 0);

    // 5: over-pop from a single entry
    push4(4'b1000);
    idle(2'd3);
    chk("t5_count", o_count, 0);
    chk("t5_hv", o_head_valid, 2'b00);

    // 6: flush beats a push, then async reset mid-burst
    push4(4'b1111); push4(4'b1111); push4(4'b1000);
    chk("t6_count9", o_count, 9);
    cycle(4'b1110, 2'd1, 1'b1, rnd_isn(), rnd_isn(), rnd_isn(), rnd_isn());
    chk("t6_flush", o_count, 0);
    push4(4'b1111); push4(4'b1111);
    i_valid = 4'b1111; i_isn1 = rnd_isn();
    #2 i_Reset_n = 1'b0;
    #1 chk("t6_async_count", o_count, 0);
    chk("t6_async_hv", o_head_valid, 2'b00);
    @(negedge i_Clk);
    i_Reset_n = 1'b1; i_valid = 4'b0;
    mq.delete();
    check_all();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = 4'b1111;
      cycle(v, 2'($urandom_range(0, 3)), ($urandom_range(0, 49) == 0),
            rnd_isn(), rnd_isn(), rnd_isn(), rnd_isn());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
